// File: rtl/fp_norm_pkg.sv
// Shared definitions for the post-normalizer pipeline.
//   EXP_W_DEFAULT : default biased-exponent width
//   EXP_ALL_ONES  : Inf/NaN exponent code at the default width
//   MANT_W / LZ_W : mantissa width and leading-zero count width
//   norm_case_e   : stage-2 classification of the word being normalized
package fp_norm_pkg;

    localparam int MANT_W        = 16;
    localparam int LZ_W          = 4;
    localparam int EXP_W_DEFAULT = 8;
    localparam logic [EXP_W_DEFAULT-1:0] EXP_ALL_ONES = {EXP_W_DEFAULT{1'b1}};

    typedef enum logic [2:0] {
        NC_SPECIAL   = 3'd0,  // Inf/NaN exponent: pass through untouched
        NC_ZERO      = 3'd1,  // zero mantissa: canonical zero
        NC_DENORM_IN = 3'd2,  // already denormal: keep as is
        NC_SHIFT     = 3'd3,  // full normalization fits in the exponent
        NC_CLAMP     = 3'd4   // exponent runs out first: clamp to denormal
    } norm_case_e;

endpackage

// File: rtl/fp_normalize_pipe_lzc.sv
// LZC_16: combinational leading-zero counter for a 16-bit word.
//   A     : input word
//   R     : number of leading zeros (wraps to 0 for an all-zero word)
//   All_0 : high when A is zero
module LZC_16
    import fp_norm_pkg::*;
(
    input  logic [MANT_W-1:0] A,
    output logic [LZ_W-1:0]   R,
    output logic              All_0
);

    logic [LZ_W-1:0] r_s;

    // Scan from LSB upward; the highest set bit is the last to write r_s.
    always_comb begin
        r_s = {LZ_W{1'b0}};
        for (int i = 0; i < MANT_W; i++) begin
            if (A[i]) begin
                r_s = LZ_W'(MANT_W - 1 - i);
            end else begin
                r_s = r_s;
            end
        end
    end

    assign R     = r_s;
    assign All_0 = (A == {MANT_W{1'b0}});

endmodule

// File: rtl/fp_normalize_pipe.sv
// fp_normalize_pipe: two-stage post-normalizer for 16-bit mantissas.
//   Stage 1 captures the word and its leading-zero count; stage 2 shifts the
//   mantissa and adjusts the biased exponent, clamping to denormal when the
//   exponent cannot absorb the full shift.
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     upstream handshake (in_ready is combinational)
//   in_sign/exp/mant      unnormalized word
//   out_valid/out_ready   downstream handshake
//   out_sign/exp/mant     normalized word
//   out_lz                shift actually applied
//   out_zero/out_denorm   zero-mantissa and clamped-to-denormal flags
module fp_normalize_pipe
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic [LZ_W-1:0]   out_lz,
    output logic              out_zero,
    output logic              out_denorm
);

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};

    logic adv1_s, adv2_s;
    logic [LZ_W-1:0] lzc_r_s;
    logic            lzc_zero_s;

    logic              s1_valid_q, s1_sign_q, s1_zero_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [MANT_W-1:0] s1_mant_q;
    logic [LZ_W-1:0]   s1_lz_q;

    logic              s2_valid_q, s2_sign_q, s2_zero_q, s2_denorm_q;
    logic [EXP_W-1:0]  s2_exp_q;
    logic [MANT_W-1:0] s2_mant_q;
    logic [LZ_W-1:0]   s2_lz_q;

    norm_case_e        ncase_s;
    logic [EXP_W-1:0]  e_m1_s, l_ext_s;
    logic [EXP_W-1:0]  s2_exp_d;
    logic [MANT_W-1:0] s2_mant_d;
    logic [LZ_W-1:0]   s2_lz_d;
    logic              s2_zero_d, s2_denorm_d;

    // A stage may load when it is empty or its contents move on this cycle.
    assign adv2_s   = ~s2_valid_q | out_ready;
    assign adv1_s   = ~s1_valid_q | adv2_s;
    assign in_ready = adv1_s & ~RESET;

    LZC_16 u_lzc (
        .A     (in_mant),
        .R     (lzc_r_s),
        .All_0 (lzc_zero_s)
    );

    // Stage 1: capture the incoming word with its leading-zero count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= EXP_ZERO;
            s1_mant_q  <= {MANT_W{1'b0}};
            s1_lz_q    <= {LZ_W{1'b0}};
            s1_zero_q  <= 1'b0;
        end else if (adv1_s) begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= in_sign;
            s1_exp_q   <= in_exp;
            s1_mant_q  <= in_mant;
            s1_lz_q    <= lzc_r_s;
            s1_zero_q  <= lzc_zero_s;
        end
    end

    // Stage 2 classification; E-1 is only consumed when E >= 1.
    always_comb begin
        e_m1_s  = s1_exp_q - EXP_ONE;
        l_ext_s = {{(EXP_W-LZ_W){1'b0}}, s1_lz_q};
        if (s1_exp_q == EXP_ONES) begin
            ncase_s = NC_SPECIAL;
        end else if (s1_zero_q) begin
            ncase_s = NC_ZERO;
        end else if (s1_exp_q == EXP_ZERO) begin
            ncase_s = NC_DENORM_IN;
        end else if (l_ext_s <= e_m1_s) begin
            ncase_s = NC_SHIFT;
        end else begin
            ncase_s = NC_CLAMP;
        end
    end

    // Stage 2 datapath: shift and exponent adjust per classification.
    always_comb begin
        s2_exp_d    = s1_exp_q;
        s2_mant_d   = s1_mant_q;
        s2_lz_d     = {LZ_W{1'b0}};
        s2_zero_d   = 1'b0;
        s2_denorm_d = 1'b0;
        case (ncase_s)
            NC_SPECIAL: begin
                s2_exp_d  = s1_exp_q;
                s2_mant_d = s1_mant_q;
            end
            NC_ZERO: begin
                s2_exp_d  = EXP_ZERO;
                s2_mant_d = {MANT_W{1'b0}};
                s2_zero_d = 1'b1;
            end
            NC_DENORM_IN: begin
                s2_exp_d    = EXP_ZERO;
                s2_denorm_d = 1'b1;
            end
            NC_SHIFT: begin
                s2_mant_d = s1_mant_q << s1_lz_q;
                s2_exp_d  = s1_exp_q - l_ext_s;
                s2_lz_d   = s1_lz_q;
            end
            NC_CLAMP: begin
                // E-1 < L <= 15 here, so the low LZ_W bits hold the whole shift.
                s2_mant_d   = s1_mant_q << e_m1_s[LZ_W-1:0];
                s2_exp_d    = EXP_ZERO;
                s2_lz_d     = e_m1_s[LZ_W-1:0];
                s2_denorm_d = 1'b1;
            end
            default: begin
                s2_exp_d  = s1_exp_q;
                s2_mant_d = s1_mant_q;
            end
        endcase
    end

    // Stage 2 register: holds while the downstream stalls.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= EXP_ZERO;
            s2_mant_q   <= {MANT_W{1'b0}};
            s2_lz_q     <= {LZ_W{1'b0}};
            s2_zero_q   <= 1'b0;
            s2_denorm_q <= 1'b0;
        end else if (adv2_s) begin
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_exp_q    <= s2_exp_d;
            s2_mant_q   <= s2_mant_d;
            s2_lz_q     <= s2_lz_d;
            s2_zero_q   <= s2_zero_d;
            s2_denorm_q <= s2_denorm_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_sign   = s2_sign_q;
    assign out_exp    = s2_exp_q;
    assign out_mant   = s2_mant_q;
    assign out_lz     = s2_lz_q;
    assign out_zero   = s2_zero_q;
    assign out_denorm = s2_denorm_q;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Scoreboard bench for fp_normalize_pipe (EXP_W = 8): directed corner words,
// a stall/backpressure sequence, a mid-flight reset, then randomized traffic
// with random downstream backpressure against a behavioural model.
module tb_fp_normalize_pipe;
    import fp_norm_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'h00;
    logic [15:0] in_mant = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [15:0] out_mant;
    logic [3:0]  out_lz;
    logic        out_zero;
    logic        out_denorm;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [15:0] m;
        logic [3:0]  lz;
        logic        z;
        logic        d;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_cnt = 0;
    bit   rand_rdy = 1'b0;

    fp_normalize_pipe #(.EXP_W(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_mant   (out_mant),
        .out_lz     (out_lz),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: normalize as far as the exponent allows, in plain arithmetic.
    function automatic exp_t model(logic s, logic [7:0] e, logic [15:0] m);
        exp_t r;
        int lz;
        int ei;
        ei = int'(e);
        r.s = s; r.e = 8'h00; r.m = 16'h0000; r.lz = 4'd0; r.z = 1'b0; r.d = 1'b0;
        r.cyc = 0; r.lat = 1'b0;
        if (e == EXP_ALL_ONES) begin
            r.e = e; r.m = m;
        end else if (m == 16'h0000) begin
            r.z = 1'b1;
        end else if (e == 8'h00) begin
            r.m = m; r.d = 1'b1;
        end else begin
            lz = 0;
            while (m[15-lz] == 1'b0) lz++;
            if (lz <= ei - 1) begin
                r.m = m << lz; r.e = 8'(ei - lz); r.lz = 4'(lz);
            end else begin
                r.m = m << (ei - 1); r.e = 8'h00; r.d = 1'b1; r.lz = 4'(ei - 1);
            end
        end
        return r;
    endfunction

    // Offer one word until accepted; push its expected result on acceptance.
    task automatic send(input logic s, input logic [7:0] e, input logic [15:0] m, input bit lat);
        exp_t ent;
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        for (int k = 0; k < 200; k++) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            if (in_ready) begin
                ent = model(s, e, m);
                ent.cyc = cyc_cnt;
                ent.lat = lat;
                sb_q.push_back(ent);
                acc = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: got no in_ready expected acceptance");
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: pop and compare on every output transfer; check stall stability.
    logic [30:0] held_word;
    bit          held = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_data", {1'b0, out_sign, out_exp, out_mant, out_lz, out_zero, out_denorm},
                        {1'b0, held_word});
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out: got mant %0h expected no output", out_mant);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sign", {31'd0, out_sign}, {31'd0, e.s});
                        chk("exp", {24'd0, out_exp}, {24'd0, e.e});
                        chk("mant", {16'd0, out_mant}, {16'd0, e.m});
                        chk("lz", {28'd0, out_lz}, {28'd0, e.lz});
                        chk("zero", {31'd0, out_zero}, {31'd0, e.z});
                        chk("denorm", {31'd0, out_denorm}, {31'd0, e.d});
                        if (e.lat) chk("latency", 32'(cyc_cnt - e.cyc), 32'd2);
                    end
                    held = 1'b0;
                end else if (out_valid) begin
                    held = 1'b1;
                    held_word = {out_sign, out_exp, out_mant, out_lz, out_zero, out_denorm};
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [7:0]  re;
        logic [15:0] rm;
        // Reset state.
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_mant", {16'd0, out_mant}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        out_ready = 1'b1;

        // Directed corner words, back to back with out_ready high.
        send(1'b0, 8'd20,  16'h0010, 1'b1);
        send(1'b1, 8'd5,   16'h0001, 1'b1);
        send(1'b0, 8'h40,  16'h0000, 1'b1);
        send(1'b1, 8'hFF,  16'h0123, 1'b1);
        send(1'b0, 8'h00,  16'h0F00, 1'b1);
        send(1'b0, 8'd16,  16'h0001, 1'b1);
        send(1'b0, 8'd1,   16'h0800, 1'b1);
        repeat (4) @(posedge CLK);
        #1;

        // Backpressure: fill both stages, then the third word must wait.
        out_ready = 1'b0;
        send(1'b0, 8'd30, 16'h1234, 1'b0);
        send(1'b1, 8'd31, 16'h00F0, 1'b0);
        in_valid = 1'b1; in_exp = 8'd32; in_mant = 16'h0003;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("full_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge CLK); #1;
        end
        out_ready = 1'b1;
        send(1'b0, 8'd32, 16'h0003, 1'b0);
        send(1'b1, 8'd2,  16'h0040, 1'b0);
        send(1'b0, 8'd9,  16'h8001, 1'b0);
        send(1'b1, 8'd3,  16'h0000, 1'b0);
        repeat (4) @(posedge CLK);
        #1;

        // Reset with two words in flight.
        send(1'b0, 8'd50, 16'h0100, 1'b0);
        send(1'b0, 8'd51, 16'h0200, 1'b0);
        RESET = 1'b1;
        sb_q.delete();
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(posedge CLK);
        #1;
        send(1'b1, 8'd60, 16'h0004, 1'b1);
        repeat (3) @(posedge CLK);
        #1;

        // Randomized traffic with random backpressure and idle gaps.
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: re = 8'h00;
                1: re = 8'h01;
                2: re = 8'hFF;
                3: re = 8'($urandom_range(2, 16));
                default: re = 8'($urandom_range(0, 255));
            endcase
            rm = 16'($urandom);
            rm = rm >> $urandom_range(0, 16);
            send(1'($urandom_range(0, 1)), re, rm, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
            end
        end

        // Drain.
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (sb_q.size() == 0) break;
            @(posedge CLK); #1;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
